led_scanout: RTL and testbench

Scan-out stage directly downstream of the byte-write / word-read LED frame-buffer RAM. It walks the RAM's 32-bit read port row by row and fetches each word with the RAM's one-cycle read latency. Each word is shifted MSB-first onto a serial LED-driver bus (sdo/sclk). At the end of every row it pulses a latch and publishes the row index. Frame-buffer RAM and scan-out run on the same clock.

---
 rtl/led_scanout.sv | 160 ++++++++++++++++
 tb/tb_led_scanout.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scanout.sv
// Scan-out stage for the LED frame buffer. It reads 32-bit words over the RAM read port,
// shifts each word MSB-first onto sdo/sclk, and pulses a latch at the end of every row.
module led_scanout #(
   parameter int WORDS_PER_ROW = 8,
   parameter int ROWS          = 64,
   parameter int CLKDIV        = 2,
   localparam int AW           = $clog2(WORDS_PER_ROW * ROWS),
   localparam int RW           = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic [AW-1:0] addrb,
   input  logic [31:0]   dob,
   output logic          sdo,
   output logic          sclk,
   output logic          latch,
   output logic [RW-1:0] row,
   output logic          frame_done,
   output logic          busy
);

   localparam int WW = $clog2(WORDS_PER_ROW);
   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
   localparam logic [AW-1:0] WORD_LAST = AW'(WORDS_PER_ROW - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(WORDS_PER_ROW * ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_FETCH,
      S_SHIFT,
      S_LATCH
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addrb_q, addrb_d;
   logic [30:0]   shreg_q, shreg_d;   // bits still to be shifted after the one on sdo
   logic [4:0]    bit_q, bit_d;
   logic [DW-1:0] div_q, div_d;
   logic          sdo_q, sdo_d;
   logic          sclk_q, sclk_d;
   logic          latch_q, latch_d;
   logic [RW-1:0] row_q, row_d;
   logic          frame_done_q, frame_done_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d      = state_q;
      addrb_d      = addrb_q;
      shreg_d      = shreg_q;
      bit_d        = bit_q;
      div_d        = div_q;
      sdo_d        = sdo_q;
      sclk_d       = sclk_q;
      latch_d      = latch_q;
      row_d        = row_q;
      frame_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_ADDR;
         end
         S_ADDR: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            shreg_d = dob[30:0];
            sdo_d   = dob[31];
            sclk_d  = 1'b0;
            bit_d   = 5'd31;
            div_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + DW'(1);
            end else begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // End of a high phase: the driver has sampled the current bit.
                  sclk_d = 1'b0;
                  if (bit_q != 5'd0) begin
                     bit_d   = bit_q - 5'd1;
                     sdo_d   = shreg_q[30];
                     shreg_d = {shreg_q[29:0], 1'b0};
                  end else if ((addrb_q & WORD_LAST) != WORD_LAST) begin
                     addrb_d = addrb_q + AW'(1);
                     state_d = S_ADDR;
                  end else begin
                     latch_d = 1'b1;
                     row_d   = RW'(addrb_q >> WW);
                     state_d = S_LATCH;
                  end
               end
            end
         end
         S_LATCH: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + DW'(1);
            end else begin
               div_d   = '0;
               latch_d = 1'b0;
               addrb_d = addrb_q + AW'(1);
               if (addrb_q == ADDR_LAST) begin
                  frame_done_d = 1'b1;
                  state_d      = en ? S_ADDR : S_IDLE;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addrb_q      <= '0;
         shreg_q      <= '0;
         bit_q        <= '0;
         div_q        <= '0;
         sdo_q        <= 1'b0;
         sclk_q       <= 1'b0;
         latch_q      <= 1'b0;
         row_q        <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addrb_q      <= addrb_d;
         shreg_q      <= shreg_d;
         bit_q        <= bit_d;
         div_q        <= div_d;
         sdo_q        <= sdo_d;
         sclk_q       <= sclk_d;
         latch_q      <= latch_d;
         row_q        <= row_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign addrb      = addrb_q;
   assign sdo        = sdo_q;
   assign sclk       = sclk_q;
   assign latch      = latch_q;
   assign row        = row_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_led_scanout.sv
// Bench for led_scanout: a full-size instance for word/row timing and reset abort, and two
// reduced instances for frame wrap, en-drop and CLKDIV=1 behaviour within a short run.
module tb_led_scanout;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Instance A: default geometry
   logic        rst_n_a, en_a, sdo_a, sclk_a, latch_a, fd_a, busy_a;
   logic [8:0]  addrb_a;
   logic [5:0]  row_a;
   logic [31:0] dob_a;
   logic [31:0] mem_a [512];

   // Instance B: 2 words x 4 rows, CLKDIV=2
   logic        rst_n_b, en_b, sdo_b, sclk_b, latch_b, fd_b, busy_b;
   logic [2:0]  addrb_b;
   logic [1:0]  row_b;
   logic [31:0] dob_b;
   logic [31:0] mem_b [8];

   // Instance C: 2 words x 2 rows, CLKDIV=1
   logic        rst_n_c, en_c, sdo_c, sclk_c, latch_c, fd_c, busy_c;
   logic [1:0]  addrb_c;
   logic [0:0]  row_c;
   logic [31:0] dob_c;
   logic [31:0] mem_c [4];

   led_scanout dut_a (
      .clk(clk), .rst_n(rst_n_a), .en(en_a), .addrb(addrb_a), .dob(dob_a), .sdo(sdo_a),
      .sclk(sclk_a), .latch(latch_a), .row(row_a), .frame_done(fd_a), .busy(busy_a)
   );

   led_scanout #(.WORDS_PER_ROW(2), .ROWS(4), .CLKDIV(2)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .en(en_b), .addrb(addrb_b), .dob(dob_b), .sdo(sdo_b),
      .sclk(sclk_b), .latch(latch_b), .row(row_b), .frame_done(fd_b), .busy(busy_b)
   );

   led_scanout #(.WORDS_PER_ROW(2), .ROWS(2), .CLKDIV(1)) dut_c (
      .clk(clk), .rst_n(rst_n_c), .en(en_c), .addrb(addrb_c), .dob(dob_c), .sdo(sdo_c),
      .sclk(sclk_c), .latch(latch_c), .row(row_c), .frame_done(fd_c), .busy(busy_c)
   );

   // Frame-buffer read ports: one-cycle registered read
   always @(posedge clk) begin
      dob_a <= mem_a[addrb_a];
      dob_b <= mem_b[addrb_b];
      dob_c <= mem_c[addrb_c];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboards: expected {address, bit} per sclk rising edge
   typedef struct packed {
      logic [8:0] addr;
      logic       b;
   } sb_t;

   sb_t  q_a[$];
   sb_t  q_c[$];
   logic sclk_prev_a = 1'b0;
   logic sclk_prev_c = 1'b0;

   always @(negedge clk) begin
      sclk_prev_a <= sclk_a;
      if (sclk_a && !sclk_prev_a && q_a.size() > 0) begin
         check("a_sdo", 32'(sdo_a), 32'(q_a[0].b));
         check("a_addrb_bit", 32'(addrb_a), 32'(q_a[0].addr));
         q_a.delete(0);
      end
   end

   always @(negedge clk) begin
      sclk_prev_c <= sclk_c;
      if (sclk_c && !sclk_prev_c && q_c.size() > 0) begin
         check("c_sdo", 32'(sdo_c), 32'(q_c[0].b));
         check("c_addrb_bit", 32'(addrb_c), 32'(q_c[0].addr));
         q_c.delete(0);
      end
   end

   task automatic push_a(input int first, input int count);
      for (int w = first; w < first + count; w++)
         for (int k = 31; k >= 0; k--)
            q_a.push_back('{addr: 9'(w), b: mem_a[w][k]});
   endtask

   task automatic push_c(input int first, input int count);
      for (int w = first; w < first + count; w++)
         for (int k = 31; k >= 0; k--)
            q_c.push_back('{addr: 9'(w), b: mem_c[w][k]});
   endtask

   // Timing vectors for instance A, indexed by clock edges since en was raised
   typedef struct {
      int         cyc;
      logic [8:0] addrb;
      logic       sclk;
      logic       latch;
      logic [5:0] row;
      logic       busy;
      logic       fd;
   } vec_t;

   function automatic vec_t mk_vec(input int c, input int a, input bit s, input bit l,
                                   input int r, input bit bz, input bit f);
      vec_t v;
      v.cyc   = c;
      v.addrb = 9'(a);
      v.sclk  = s;
      v.latch = l;
      v.row   = 6'(r);
      v.busy  = bz;
      v.fd    = f;
      return v;
   endfunction

   task automatic check_idle_a(input string tag);
      check({tag, "_addrb"}, 32'(addrb_a), 32'd0);
      check({tag, "_sdo"}, 32'(sdo_a), 32'd0);
      check({tag, "_sclk"}, 32'(sclk_a), 32'd0);
      check({tag, "_latch"}, 32'(latch_a), 32'd0);
      check({tag, "_row"}, 32'(row_a), 32'd0);
      check({tag, "_fd"}, 32'(fd_a), 32'd0);
      check({tag, "_busy"}, 32'(busy_a), 32'd0);
   endtask

   task automatic run_a();
      vec_t vecs[15];
      int   idx = 0;
      vecs[0]  = mk_vec(1,    0,  0, 0, 0, 1, 0);
      vecs[1]  = mk_vec(2,    0,  0, 0, 0, 1, 0);
      vecs[2]  = mk_vec(4,    0,  0, 0, 0, 1, 0);
      vecs[3]  = mk_vec(5,    0,  1, 0, 0, 1, 0);
      vecs[4]  = mk_vec(6,    0,  1, 0, 0, 1, 0);
      vecs[5]  = mk_vec(7,    0,  0, 0, 0, 1, 0);
      vecs[6]  = mk_vec(130,  0,  1, 0, 0, 1, 0);
      vecs[7]  = mk_vec(131,  1,  0, 0, 0, 1, 0);
      vecs[8]  = mk_vec(1040, 7,  1, 0, 0, 1, 0);
      vecs[9]  = mk_vec(1041, 7,  0, 1, 0, 1, 0);
      vecs[10] = mk_vec(1042, 7,  0, 1, 0, 1, 0);
      vecs[11] = mk_vec(1043, 8,  0, 0, 0, 1, 0);
      vecs[12] = mk_vec(2083, 15, 0, 1, 1, 1, 0);
      vecs[13] = mk_vec(2084, 15, 0, 1, 1, 1, 0);
      vecs[14] = mk_vec(2085, 16, 0, 0, 1, 1, 0);

      push_a(0, 16);
      en_a = 1'b1;
      for (int n = 1; n <= 2535; n++) begin
         @(negedge clk);
         if (idx < 15 && n == vecs[idx].cyc) begin
            check($sformatf("a_v%0d_addrb", n), 32'(addrb_a), 32'(vecs[idx].addrb));
            check($sformatf("a_v%0d_sclk", n), 32'(sclk_a), 32'(vecs[idx].sclk));
            check($sformatf("a_v%0d_latch", n), 32'(latch_a), 32'(vecs[idx].latch));
            check($sformatf("a_v%0d_row", n), 32'(row_a), 32'(vecs[idx].row));
            check($sformatf("a_v%0d_busy", n), 32'(busy_a), 32'(vecs[idx].busy));
            check($sformatf("a_v%0d_fd", n), 32'(fd_a), 32'(vecs[idx].fd));
            idx++;
         end
         if (n == 2100) check("a_sb_drain", 32'(q_a.size()), 32'd0);
      end

      // Row 2, word 3, high phase of bit 17: abort with reset
      check("a_prereset_sclk", 32'(sclk_a), 32'd1);
      check("a_prereset_addrb", 32'(addrb_a), 32'd19);
      check("a_prereset_sdo", 32'(sdo_a), 32'(mem_a[19][17]));
      rst_n_a = 1'b0;
      @(negedge clk);
      check_idle_a("a_abort");
      push_a(0, 2);
      rst_n_a = 1'b1;
      @(negedge clk);
      check("a_restart_busy", 32'(busy_a), 32'd1);
      check("a_restart_addrb", 32'(addrb_a), 32'd0);
      for (int t = 0; t < 300 && q_a.size() > 0; t++) @(negedge clk);
      check("a_restart_drain", 32'(q_a.size()), 32'd0);
      en_a    = 1'b0;
      rst_n_a = 1'b0;
   endtask

   task automatic run_b();
      int fd_cyc[$];
      int busy_drop = 0;
      int busy_after = 0;
      en_b = 1'b1;
      for (int n = 1; n <= 2100; n++) begin
         @(negedge clk);
         if (!busy_b) busy_drop++;
         if (fd_b) fd_cyc.push_back(n);
         if (n == 1048) begin
            check("b_lastlatch_addrb", 32'(addrb_b), 32'd7);
            check("b_lastlatch_latch", 32'(latch_b), 32'd1);
            check("b_lastlatch_row", 32'(row_b), 32'd3);
         end
         if (n == 1049) check("b_wrap_addrb", 32'(addrb_b), 32'd0);
         if (n == 1050) check("b_fd_width", 32'(fd_b), 32'd0);
      end
      check("b_fd_count", 32'(fd_cyc.size()), 32'd2);
      check("b_fd_first", 32'(fd_cyc.size() > 0 ? fd_cyc[0] : -1), 32'd1049);
      check("b_fd_second", 32'(fd_cyc.size() > 1 ? fd_cyc[1] : -1), 32'd2097);
      check("b_busy_held", 32'(busy_drop), 32'd0);

      fd_cyc.delete();
      busy_drop = 0;
      for (int n = 2101; n <= 3300; n++) begin
         @(negedge clk);
         if (n == 2400) en_b = 1'b0;   // row 1 of the third frame
         if (n <= 3144 && !busy_b) busy_drop++;
         if (n >= 3146 && busy_b) busy_after++;
         if (fd_b) fd_cyc.push_back(n);
         if (n == 3144) check("b_endrow_row", 32'(row_b), 32'd3);
         if (n == 3146 || n == 3300) begin
            check($sformatf("b_idle%0d_busy", n), 32'(busy_b), 32'd0);
            check($sformatf("b_idle%0d_sclk", n), 32'(sclk_b), 32'd0);
            check($sformatf("b_idle%0d_addrb", n), 32'(addrb_b), 32'd0);
         end
      end
      check("b_stop_fd_count", 32'(fd_cyc.size()), 32'd1);
      check("b_stop_fd_cyc", 32'(fd_cyc.size() > 0 ? fd_cyc[0] : -1), 32'd3145);
      check("b_stop_busy_held", 32'(busy_drop), 32'd0);
      check("b_stop_busy_after", 32'(busy_after), 32'd0);
   endtask

   task automatic run_c();
      push_c(0, 2);
      en_c = 1'b1;
      for (int n = 1; n <= 140; n++) begin
         @(negedge clk);
         case (n)
            1: begin
               check("c_n1_busy", 32'(busy_c), 32'd1);
               check("c_n1_addrb", 32'(addrb_c), 32'd0);
            end
            3, 5: check($sformatf("c_n%0d_sclk", n), 32'(sclk_c), 32'd0);
            4, 6: check($sformatf("c_n%0d_sclk", n), 32'(sclk_c), 32'd1);
            66: begin
               check("c_n66_sclk", 32'(sclk_c), 32'd1);
               check("c_n66_addrb", 32'(addrb_c), 32'd0);
            end
            67: begin
               check("c_n67_sclk", 32'(sclk_c), 32'd0);
               check("c_n67_addrb", 32'(addrb_c), 32'd1);
            end
            133: begin
               check("c_n133_latch", 32'(latch_c), 32'd1);
               check("c_n133_row", 32'(row_c), 32'd0);
            end
            134: begin
               check("c_n134_latch", 32'(latch_c), 32'd0);
               check("c_n134_addrb", 32'(addrb_c), 32'd2);
            end
            default: ;
         endcase
      end
      check("c_sb_drain", 32'(q_c.size()), 32'd0);
      en_c = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 512; i++)
         mem_a[i] = (i < 8) ? 32'h8765_4321 : (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      for (int i = 0; i < 8; i++) mem_b[i] = 32'h1111_1111 * 32'(i + 1);
      mem_c[0] = 32'hF0E1_D2C3;
      mem_c[1] = 32'h0123_4567;
      mem_c[2] = 32'hAAAA_5555;
      mem_c[3] = 32'h8000_0001;

      rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
      en_a = 1'b1; en_b = 1'b0; en_c = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_a("a_reset");
      check("b_reset_busy", 32'(busy_b), 32'd0);
      check("c_reset_addrb", 32'(addrb_c), 32'd0);
      en_a    = 1'b0;
      rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
      repeat (2) @(negedge clk);
      check("a_idle_busy", 32'(busy_a), 32'd0);
      check("a_idle_sclk", 32'(sclk_a), 32'd0);

      run_a();
      run_b();
      run_c();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
